// File: rtl/filt_decim_fifo.sv
// Boxcar decimator for the 8-bit IIR filter output. Decimated samples go into a
// first-word-fall-through FIFO that is drained over valid/ready, with a sticky overflow flag.
module filt_decim_fifo #(
  parameter int DECIM_LOG2 = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int AW    = 8 + DECIM_LOG2;
  localparam int PW    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] LAST_PHASE = PW'((1 << DECIM_LOG2) - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic signed [AW-1:0]   r_acc;
  logic [PW-1:0]          r_phase;
  logic [7:0]             r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  r_wr_ptr;
  logic [DEPTH_LOG2-1:0]  r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_valid;
  logic                   r_ovf;

  logic signed [AW-1:0]   w_sum;
  logic [7:0]             w_result;
  logic                   w_block_end;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_write;
  logic                   w_drop;
  logic [CW-1:0]          w_count_next;

  // With DECIM_LOG2=0 the phase stays at 0, so every enabled sample ends a block.
  always_comb begin
    w_sum        = r_acc + AW'($signed(din));
    w_result     = 8'(w_sum >>> DECIM_LOG2);
    w_block_end  = (r_phase == LAST_PHASE);
    w_push       = en & w_block_end;
    w_pop        = r_valid & dout_ready;
    w_full       = (r_count == FULL_COUNT);
    w_write      = w_push & (~w_full | w_pop);
    w_drop       = w_push & w_full & ~w_pop;
    w_count_next = r_count;
    case ({w_write, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (en) begin
      if (w_block_end) begin
        r_acc   <= '0;
        r_phase <= '0;
      end else begin
        r_acc   <= w_sum;
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_result;
  end

  // A dropped push on the same edge as clr_ovf leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  always_comb begin
    dout       = r_valid ? r_mem[r_rd_ptr] : '0;
    dout_valid = r_valid;
    count      = r_count;
    ovf        = r_ovf;
  end

endmodule

// File: tb/tb_filt_decim_fifo.sv
// Bench for filt_decim_fifo: a DECIM_LOG2=2 and a DECIM_LOG2=0 instance share stimulus,
// each is checked every cycle against a queue-based model, plus literal spot values.
module tb_filt_decim_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic       ready;
  logic       clr;

  logic [7:0] dout_w  [2];
  logic       valid_w [2];
  logic [4:0] count_w [2];
  logic       ovf_w   [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  filt_decim_fifo #(.DECIM_LOG2(2), .DEPTH_LOG2(4)) u_dut_d4 (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout_w[0]), .dout_valid(valid_w[0]), .dout_ready(ready),
    .count(count_w[0]), .ovf(ovf_w[0]), .clr_ovf(clr)
  );

  filt_decim_fifo #(.DECIM_LOG2(0), .DEPTH_LOG2(4)) u_dut_d1 (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout_w[1]), .dout_valid(valid_w[1]), .dout_ready(ready),
    .count(count_w[1]), .ovf(ovf_w[1]), .clr_ovf(clr)
  );

  task automatic cmp(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Block average rounded toward minus infinity, reduced to 8-bit two's complement.
  function automatic int floor_avg(input int sum, input int n);
    int r;
    if (sum >= 0) r = sum / n;
    else          r = -((-sum + n - 1) / n);
    return r & 255;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_model
    localparam int N = (k == 0) ? 4 : 1;
    int q[$];
    int bsum;
    int bn;
    bit movf;

    always @(posedge clk) begin
      bit pop;
      bit push;
      bit full;
      int res;
      if (rst) begin
        q.delete();
        bsum = 0;
        bn   = 0;
        movf = 1'b0;
      end else begin
        pop  = (q.size() > 0) && ready;
        full = (q.size() == 16);
        push = 1'b0;
        res  = 0;
        if (en) begin
          bsum += int'($signed(din));
          bn++;
          if (bn == N) begin
            res  = floor_avg(bsum, N);
            push = 1'b1;
            bsum = 0;
            bn   = 0;
          end
        end
        if (pop) void'(q.pop_front());
        if (push && full && !pop) movf = 1'b1;
        else begin
          if (push) q.push_back(res);
          if (clr) movf = 1'b0;
        end
      end
    end

    always @(negedge clk) begin
      cmp($sformatf("dout[%0d]", k),  int'(dout_w[k]),  (q.size() > 0) ? q[0] : 0);
      cmp($sformatf("valid[%0d]", k), int'(valid_w[k]), int'(q.size() > 0));
      cmp($sformatf("count[%0d]", k), int'(count_w[k]), q.size());
      cmp($sformatf("ovf[%0d]", k),   int'(ovf_w[k]),   int'(movf));
    end
  end

  task automatic step(input logic e, input logic [7:0] d, input logic r, input logic c);
    en    = e;
    din   = d;
    ready = r;
    clr   = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic block4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b0);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; ready = 1'b0; clr = 1'b0;
    do_reset();
    cmp("reset_valid", int'(valid_w[0]), 0);
    cmp("reset_dout",  int'(dout_w[0]),  0);
    cmp("reset_count", int'(count_w[0]), 0);
    cmp("reset_ovf",   int'(ovf_w[0]),   0);

    // constant block, latency and FWFT pops
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h10, 1'b0, 1'b0);
      if (i == 2) cmp("t1_not_yet", int'(valid_w[0]), 0);
      if (i == 3) begin
        cmp("t1_valid_rise", int'(valid_w[0]), 1);
        cmp("t1_first_dout", int'(dout_w[0]), 8'h10);
      end
    end
    cmp("t1_count2", int'(count_w[0]), 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("t1_pop1_dout", int'(dout_w[0]), 8'h10);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("t1_pop2_count", int'(count_w[0]), 0);
    cmp("t1_empty_dout", int'(dout_w[0]), 0);

    // signed floor rounding
    do_reset(); block4(8'hFF, 8'hFE, 8'hFF, 8'hFE);
    cmp("t2_neg6", int'(dout_w[0]), 8'hFE);
    do_reset(); block4(8'h01, 8'h00, 8'h00, 8'h00);
    cmp("t2_one", int'(dout_w[0]), 8'h00);
    do_reset(); block4(8'h80, 8'h80, 8'h80, 8'h80);
    cmp("t2_min", int'(dout_w[0]), 8'h80);
    do_reset(); block4(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    cmp("t2_max", int'(dout_w[0]), 8'h7F);

    // overflow, drain order, clear, set-beats-clear
    do_reset();
    for (int b = 1; b <= 17; b++) begin
      block4(8'(b), 8'(b), 8'(b), 8'(b));
      if (b == 16) cmp("t3_full_no_ovf", int'(ovf_w[0]), 0);
    end
    cmp("t3_count16", int'(count_w[0]), 16);
    cmp("t3_ovf_set", int'(ovf_w[0]), 1);
    for (int b = 1; b <= 16; b++) begin
      cmp("t3_drain", int'(dout_w[0]), b);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cmp("t3_drained", int'(count_w[0]), 0);
    cmp("t3_ovf_sticky", int'(ovf_w[0]), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("t3_ovf_clr", int'(ovf_w[0]), 0);
    for (int b = 1; b <= 16; b++) block4(8'(b), 8'(b), 8'(b), 8'(b));
    for (int i = 0; i < 4; i++) step(1'b1, 8'h11, 1'b0, 1'b1);
    cmp("t3_set_wins", int'(ovf_w[0]), 1);

    // full FIFO with push and pop on the same edge
    step(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("t4_ovf_clr", int'(ovf_w[0]), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    cmp("t4_count16", int'(count_w[0]), 16);
    cmp("t4_no_ovf", int'(ovf_w[0]), 0);
    cmp("t4_head2", int'(dout_w[0]), 2);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("t4_last", int'(dout_w[0]), 8'h55);
    cmp("t4_last_count", int'(count_w[0]), 1);

    // enable gaps, then reset mid-block
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step((i % 2) == 0, 8'h08, 1'b0, 1'b0);
      if (i == 5) cmp("t5_gap_pending", int'(count_w[0]), 0);
    end
    cmp("t5_gap_count", int'(count_w[0]), 1);
    cmp("t5_gap_dout", int'(dout_w[0]), 8'h08);
    do_reset();
    step(1'b1, 8'h40, 1'b0, 1'b0);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    do_reset();
    cmp("t5_rst_empty", int'(valid_w[0]), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h04, 1'b0, 1'b0);
    cmp("t5_rst_dout", int'(dout_w[0]), 8'h04);
    cmp("t5_rst_count", int'(count_w[0]), 1);

    // pass-through instance with sustained ready
    do_reset();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'(8'h93 + 8'(i * 37));
      step(1'b1, v, 1'b1, 1'b0);
      cmp("t6_pass_dout", int'(dout_w[1]), int'(v));
      cmp("t6_pass_count", int'(count_w[1]), 1);
    end
    cmp("t6_no_ovf", int'(ovf_w[1]), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("t6_drained", int'(count_w[1]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/filt_decim_fifo.md
Name: filt_decim_fifo

Overview:
Downstream consumer of the 8-bit IIR filter output stage. Averages non-overlapping blocks of 2^DECIM_LOG2 filter output samples (boxcar decimation) and buffers the results in a first-word-fall-through FIFO. Readers drain the FIFO over a valid/ready handshake. Overflow is reported on a sticky flag.

Parameters:
DECIM_LOG2, 2, log2 of decimation factor; legal 0..4; 0 = pass-through, every enabled sample pushed.
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  sample strobe; din consumed on every clk edge where en=1.
din  input  8  filter output sample, two's complement signed.
dout  output  8  FIFO head (decimated sample), two's complement; 8'h00 when FIFO empty.
dout_valid  output  1  FIFO non-empty.
dout_ready  input  1  reader accepts head; pop on edge where dout_valid=1 and dout_ready=1.
count  output  DEPTH_LOG2+1  number of entries held, 0..2^DEPTH_LOG2.
ovf  output  1  sticky overflow flag.
clr_ovf  input  1  clears ovf.

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous, active-high.
- Reset: acc=0, phase=0, wr_ptr=rd_ptr=0, count=0, ovf=0, dout_valid=0, dout=8'h00. FIFO contents are discarded.
- Reset mid-block drops the partial accumulation. The next block starts with the first enabled sample after reset.
- Accumulator:
  - Signed, width 8+DECIM_LOG2. Each enabled sample is sign-extended before being added; the accumulator never overflows.
  - The phase counter (DECIM_LOG2 bits) increments on each enabled sample.
  - en=0: acc and phase hold.
- Block end: the enabled edge with phase=2^DECIM_LOG2-1.
  - sum = acc + sext(din).
  - result = sum arithmetic-shifted right by DECIM_LOG2. Truncation rounds toward minus infinity, matching the filter's dropped-bit truncation.
  - result is pushed to FIFO on that same edge; acc and phase return to 0.
- Latency: dout_valid rises and dout shows the result on the cycle after the block-end edge, provided the FIFO was empty.
- FIFO:
  - 2^DEPTH_LOG2 x 8 storage; pointers wrap modulo depth.
  - First-word-fall-through: dout = mem[rd_ptr] whenever count>0.
  - Pop: dout_valid and dout_ready at edge → rd_ptr++, count--.
  - Push not full: write at wr_ptr, wr_ptr++, count++.
  - Push and pop same edge: both pointers advance, count unchanged. This includes the full case, where the push is accepted.
  - Push when full and no pop: sample dropped, pointers and count unchanged, ovf set.
  - Empty: dout_ready is ignored; no underflow possible.
- ovf:
  - Set by a dropped push.
  - Cleared by clr_ovf=1. If a set and a clear occur on the same edge, set wins.
  - Otherwise holds until rst.
- count and dout_valid are registered outputs; dout_valid = (count != 0).

Test Plan:
1. DECIM_LOG2=2, rst then en=1, din=8'h10 for 8 cycles, dout_ready=0 → dout_valid rises 1 cycle after 4th sample edge; count reaches 2; two pops yield 8'h10, 8'h10.
2. Signed rounding: samples FF,FE,FF,FE (sum -6) → dout=8'hFE (-2, floor). Samples 01,00,00,00 → 8'h00. Samples 80 x4 → 8'h80; 7F x4 → 8'h7F.
3. Overflow: dout_ready=0, 17 blocks of distinct constants 8'h01..8'h11 → count=16, ovf=1 after 17th block; drain returns 01..10 in order; clr_ovf=1 clears ovf; ovf+clr same edge → ovf stays 1.
4. Full with simultaneous push and pop: FIFO full, dout_ready=1 on block-end edge → count stays 16, ovf stays 0, new value appears last.
5. en gaps and reset: en toggles 1,0,1,0 with din 8'h08 → phase holds during en=0, one output after 4 enabled samples. rst after 2 samples of 8'h40, then 4 samples of 8'h04 → single output 8'h04, FIFO empty immediately after rst.
6. DECIM_LOG2=0: each enabled sample appears on dout one cycle later, unchanged; sustained dout_ready=1 keeps count ≤1 and ovf=0.
